// File: rtl/sync_bus_sampler_pkg.sv
// Shared constants and FSM encoding for the bus sampler and its synchronizer.
package sync_bus_sampler_pkg;

  localparam int SYNC_LATENCY = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for an asynchronous bus; all stages clear on reset.
module synchronizer
  import sync_bus_sampler_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_LATENCY];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_LATENCY-1];

endmodule

// File: rtl/sync_bus_sampler.sv
// Synchronizes an async bus, qualifies values stable for STABLE_CYCLES clocks and
// delivers each qualified change once; drops that arrive while a value is pending set overrun.
module sync_bus_sampler
  import sync_bus_sampler_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 overrun_clear,
  output logic [CNT_WIDTH-1:0] change_count,
  output state_e               fsm_state
);

  // Handshake: out_data is offered while out_valid=1 and is held constant until a
  // rising edge sees out_valid & out_ready; out_ready with out_valid=0 has no effect.

  localparam int STAB_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);

  logic [WIDTH-1:0]  sync_data;
  logic [WIDTH-1:0]  cand;
  logic [WIDTH-1:0]  last;
  logic [STAB_W-1:0] cnt;
  logic              qualified;
  state_e            state;

  synchronizer #(.WIDTH(WIDTH)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (in_data),
    .q     (sync_data)
  );

  // cnt saturates so a value that stays put keeps qualifying without wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand <= '0;
      cnt  <= '0;
    end else if (sync_data != cand) begin
      cand <= sync_data;
      cnt  <= '0;
    end else if (cnt != STAB_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign qualified = (cnt == STAB_MAX) && (cand != last);

  // last records the newest qualified value, delivered or dropped, so a later
  // return to it is not reported twice.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      out_data     <= '0;
      out_valid    <= 1'b0;
      last         <= '0;
      overrun      <= 1'b0;
      change_count <= '0;
    end else begin
      if (overrun_clear) overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (qualified) begin
            out_data  <= cand;
            last      <= cand;
            out_valid <= 1'b1;
            state     <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            change_count <= change_count + 1'b1;
            state        <= ST_IDLE;
          end else if (qualified && (cand != out_data)) begin
            overrun <= 1'b1;
            last    <= cand;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule
